// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and the coordinate type used by all drawers.
package vga_timing_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

    typedef logic [9:0] coord_t;
    typedef logic [7:0] frame_cnt_t;

endpackage

// File: rtl/vga_timing_if.sv
// Raster bus from the timing generator to the sprite/tile drawers and the encoder.
interface vga_timing_if;
    import vga_timing_pkg::*;

    coord_t     DrawX;
    coord_t     DrawY;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       line_start;
    logic       frame_start;
    logic       vblank_start;
    frame_cnt_t frame_count;

    modport master (
        output DrawX, DrawY, blank, hs, vs,
               line_start, frame_start, vblank_start, frame_count
    );

    modport slave (
        input  DrawX, DrawY, blank, hs, vs,
               line_start, frame_start, vblank_start, frame_count
    );

endinterface

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Depth-N shift register for a sync signal; all stages reset to 1 (sync inactive).
module sync_delay_line #(
    parameter int unsigned DEPTH = 1
) (
    input  logic vga_clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign dout = din;
        end else begin : g_shift
            logic [DEPTH-1:0] stages;

            // Shift din in at stage 0; reset flushes the line with inactive 1s.
            always_ff @(posedge vga_clk) begin
                if (reset) begin
                    stages <= '1;
                end else begin
                    stages[0] <= din;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        stages[i] <= stages[i-1];
                    end
                end
            end

            assign dout = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, visible-area decode, delayed syncs and strobes.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE  = vga_timing_pkg::H_VISIBLE,
    parameter int unsigned H_FRONT    = vga_timing_pkg::H_FRONT,
    parameter int unsigned H_SYNC     = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BACK     = vga_timing_pkg::H_BACK,
    parameter int unsigned V_VISIBLE  = vga_timing_pkg::V_VISIBLE,
    parameter int unsigned V_FRONT    = vga_timing_pkg::V_FRONT,
    parameter int unsigned V_SYNC     = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BACK     = vga_timing_pkg::V_BACK,
    parameter int unsigned SYNC_DELAY = 1
) (
    input  logic          vga_clk,
    input  logic          reset,
    vga_timing_if.master  vga
);
    import vga_timing_pkg::*;

    localparam int unsigned H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_LAST   = coord_t'(H_TOT - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOT - 1);
    localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
    localparam coord_t HS_BEGIN = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam coord_t VS_BEGIN = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

    coord_t     hc;
    coord_t     vc;
    frame_cnt_t fcnt;
    logic       run;
    logic       hs_raw;
    logic       vs_raw;

    // Raster counters: hc every clock, vc at end of line, frame count at end of frame.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hc   <= '0;
            vc   <= '0;
            fcnt <= '0;
        end else if (hc == H_LAST) begin
            hc <= '0;
            if (vc == V_LAST) begin
                vc   <= '0;
                fcnt <= fcnt + 8'd1;
            end else begin
                vc <= vc + 10'd1;
            end
        end else begin
            hc <= hc + 10'd1;
        end
    end

    // Strobe enable: low during reset and for the first cycle after release.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    // Visible-area, raw sync and strobe decode straight from the counters.
    always_comb begin
        hs_raw           = !((hc >= HS_BEGIN) && (hc < HS_END));
        vs_raw           = !((vc >= VS_BEGIN) && (vc < VS_END));
        vga.blank        = (hc < H_VIS) && (vc < V_VIS);
        vga.line_start   = run && (hc == '0);
        vga.frame_start  = run && (hc == '0) && (vc == '0);
        vga.vblank_start = run && (hc == '0) && (vc == V_VIS);
    end

    assign vga.DrawX       = hc;
    assign vga.DrawY       = vc;
    assign vga.frame_count = fcnt;

    sync_delay_line #(.DEPTH(SYNC_DELAY)) u_hs_delay (
        .vga_clk (vga_clk),
        .reset   (reset),
        .din     (hs_raw),
        .dout    (vga.hs)
    );

    sync_delay_line #(.DEPTH(SYNC_DELAY)) u_vs_delay (
        .vga_clk (vga_clk),
        .reset   (reset),
        .din     (vs_raw),
        .dout    (vga.vs)
    );

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed checks of vga_timing_gen: full-size builds (SYNC_DELAY 0/1/3) for horizontal
// timing and reset, plus a shrunken-raster build for vertical timing and frame rollover.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    logic vga_clk = 1'b0;
    logic rst_f   = 1'b1;
    logic rst_s   = 1'b1;
    int   total   = 0;
    int   bad     = 0;

    always #20 vga_clk = ~vga_clk;

    vga_timing_if if_a ();
    vga_timing_if if_0 ();
    vga_timing_if if_3 ();
    vga_timing_if if_s ();

    vga_timing_gen #(.SYNC_DELAY(1)) u_a (.vga_clk(vga_clk), .reset(rst_f), .vga(if_a));
    vga_timing_gen #(.SYNC_DELAY(0)) u_0 (.vga_clk(vga_clk), .reset(rst_f), .vga(if_0));
    vga_timing_gen #(.SYNC_DELAY(3)) u_3 (.vga_clk(vga_clk), .reset(rst_f), .vga(if_3));

    // 12 x 8 raster: visible 8x4, hsync at hc 9..10, vsync at vc 5..6, 96 clocks per frame.
    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_DELAY(1)
    ) u_s (.vga_clk(vga_clk), .reset(rst_s), .vga(if_s));

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge vga_clk);
    endtask

    initial begin
        int fall_a, rise_a, low_a, fall_0, rise_0, low_0, fall_3, rise_3, low_3;
        int bfall, brise, brise_y;
        logic pa, p0, p3, pb;
        int vs_low, vb_cnt, vb_x, vb_y, vb_ls, fs_cnt, ls_cnt, vis_cnt, vblank_vis, n;

        // Reset held for 3 clocks.
        step(3);
        chk("rst_drawx", if_a.DrawX, 0);
        chk("rst_drawy", if_a.DrawY, 0);
        chk("rst_blank", if_a.blank, 1);
        chk("rst_hs", if_a.hs, 1);
        chk("rst_vs", if_a.vs, 1);
        chk("rst_hs_d0", if_0.hs, 1);
        chk("rst_hs_d3", if_3.hs, 1);
        chk("rst_strobes", {if_a.line_start, if_a.frame_start, if_a.vblank_start}, 0);
        chk("rst_fcount", if_a.frame_count, 0);

        rst_f = 1'b0;
        #1;
        chk("rel_no_strobe", {if_a.line_start, if_a.frame_start}, 0);

        step(799);
        chk("x799", if_a.DrawX, 799);
        chk("x799_y", if_a.DrawY, 0);
        step(1);
        chk("wrap_x", if_a.DrawX, 0);
        chk("wrap_y", if_a.DrawY, 1);
        chk("wrap_line_start", if_a.line_start, 1);
        chk("wrap_no_frame", if_a.frame_start, 0);

        // Measure one full line (line 1 -> start of line 2).
        fall_a = -1; rise_a = -1; low_a = 0;
        fall_0 = -1; rise_0 = -1; low_0 = 0;
        fall_3 = -1; rise_3 = -1; low_3 = 0;
        bfall = -1; brise = -1; brise_y = -1;
        for (int k = 0; k < 800; k++) begin
            pa = if_a.hs; p0 = if_0.hs; p3 = if_3.hs; pb = if_a.blank;
            step(1);
            if (pa && !if_a.hs) fall_a = int'(if_a.DrawX);
            if (!pa && if_a.hs) rise_a = int'(if_a.DrawX);
            if (!if_a.hs) low_a++;
            if (p0 && !if_0.hs) fall_0 = int'(if_0.DrawX);
            if (!p0 && if_0.hs) rise_0 = int'(if_0.DrawX);
            if (!if_0.hs) low_0++;
            if (p3 && !if_3.hs) fall_3 = int'(if_3.DrawX);
            if (!p3 && if_3.hs) rise_3 = int'(if_3.DrawX);
            if (!if_3.hs) low_3++;
            if (pb && !if_a.blank) bfall = int'(if_a.DrawX);
            if (!pb && if_a.blank) begin
                brise = int'(if_a.DrawX);
                brise_y = int'(if_a.DrawY);
            end
        end
        chk("hs1_fall_x", fall_a, 657);
        chk("hs1_rise_x", rise_a, 753);
        chk("hs1_width", low_a, 96);
        chk("hs0_fall_x", fall_0, 656);
        chk("hs0_rise_x", rise_0, 752);
        chk("hs0_width", low_0, 96);
        chk("hs3_fall_x", fall_3, 659);
        chk("hs3_rise_x", rise_3, 755);
        chk("hs3_width", low_3, 96);
        chk("blank_fall_x", bfall, 640);
        chk("blank_rise_x", brise, 0);
        chk("blank_rise_y", brise_y, 2);

        // Reset mid-line while hs is low.
        step(1500);
        chk("mid_x", if_a.DrawX, 700);
        chk("mid_y", if_a.DrawY, 3);
        chk("mid_hs_low", if_a.hs, 0);
        chk("mid_hs3_low", if_3.hs, 0);
        rst_f = 1'b1;
        step(1);
        chk("mrst_x", if_a.DrawX, 0);
        chk("mrst_y", if_a.DrawY, 0);
        chk("mrst_hs", if_a.hs, 1);
        chk("mrst_hs3", if_3.hs, 1);
        chk("mrst_strobe", if_a.line_start, 0);
        step(1);
        rst_f = 1'b0;
        #1;
        chk("mrel_strobe", {if_a.line_start, if_a.frame_start}, 0);
        step(1);
        chk("mrel_x1", if_a.DrawX, 1);

        // Shrunken raster: vertical timing over one frame.
        rst_s = 1'b0;
        #1;
        chk("s_rel_strobe", {if_s.frame_start, if_s.line_start}, 0);
        vs_low = 0; vb_cnt = 0; vb_x = -1; vb_y = -1; vb_ls = 0;
        fs_cnt = 0; ls_cnt = 0; vis_cnt = 0; vblank_vis = 0;
        for (int k = 0; k < 96; k++) begin
            step(1);
            if (!if_s.vs) vs_low++;
            if (if_s.vblank_start) begin
                vb_cnt++;
                vb_x = int'(if_s.DrawX);
                vb_y = int'(if_s.DrawY);
                vb_ls = int'(if_s.line_start);
            end
            if (if_s.frame_start) fs_cnt++;
            if (if_s.line_start) ls_cnt++;
            if (if_s.blank) vis_cnt++;
            if (if_s.blank && if_s.DrawY >= 10'd4) vblank_vis++;
        end
        chk("s_vs_width", vs_low, 24);
        chk("s_vblank_cnt", vb_cnt, 1);
        chk("s_vblank_x", vb_x, 0);
        chk("s_vblank_y", vb_y, 4);
        chk("s_vblank_ls", vb_ls, 1);
        chk("s_frame_cnt", fs_cnt, 1);
        chk("s_line_cnt", ls_cnt, 8);
        chk("s_visible", vis_cnt, 32);
        chk("s_vblank_dark", vblank_vis, 0);
        chk("s_roll_x", if_s.DrawX, 0);
        chk("s_roll_y", if_s.DrawY, 0);
        chk("s_roll_fs", if_s.frame_start, 1);
        chk("s_roll_ls", if_s.line_start, 1);
        chk("s_fcount1", if_s.frame_count, 1);

        step(96 * 254);
        chk("s_fcount255", if_s.frame_count, 255);
        step(96);
        chk("s_fcount_wrap", if_s.frame_count, 0);
        chk("s_wrap_fs", if_s.frame_start, 1);

        // Shrunken raster: reset mid-frame, next frame_start one full frame later.
        step(50);
        chk("s_mid_x", if_s.DrawX, 2);
        chk("s_mid_y", if_s.DrawY, 4);
        rst_s = 1'b1;
        step(1);
        chk("s_mrst_xy", {if_s.DrawX, if_s.DrawY}, 0);
        chk("s_mrst_vs", if_s.vs, 1);
        chk("s_mrst_fcount", if_s.frame_count, 0);
        rst_s = 1'b0;
        #1;
        chk("s_mrel_fs", if_s.frame_start, 0);
        n = 0;
        for (int k = 0; k < 300; k++) begin
            step(1);
            n++;
            if (if_s.frame_start) break;
        end
        chk("s_next_frame", n, 96);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
